// File: rtl/hilo_mul_ctrl_pkg.sv
// Shared opcode, FSM state and op-class helpers for the HI/LO multiply controller.
package hilo_mul_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MUL   = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    function automatic logic is_mul_op(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL) ||
               (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_unsigned(input op_e op);
        return (op == OP_MULTU) || (op == OP_MADDU) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_acc(input op_e op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub(input op_e op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/hilo_mul_ctrl_acc.sv
// Combinational next-value of {HI,LO}: pass, accumulate or subtract the multiplier product.
module hilo_acc
    import hilo_mul_ctrl_pkg::*;
(
    input  logic        [3:0]  i_op,
    input  logic        [31:0] i_hi,
    input  logic        [31:0] i_lo,
    input  logic        [63:0] i_result,
    output logic        [63:0] o_acc
);
    op_e w_op;
    assign w_op = op_e'(i_op);

    always_comb begin
        o_acc = i_result;
        if (is_acc(w_op)) begin
            o_acc = is_sub(w_op) ? ({i_hi, i_lo} - i_result) : ({i_hi, i_lo} + i_result);
        end
    end
endmodule

// File: rtl/hilo_mul_ctrl.sv
// EX-stage controller: launches the external 2-cycle multiplier, stalls the pipe, and owns HI/LO.
module hilo_mul_ctrl
    import hilo_mul_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src_a,
    input  logic [31:0] req_src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    output logic        mul_start,
    output logic        mul_unsigned,
    input  logic [63:0] mul_result,
    input  logic        mul_done,
    output logic        timeout_err
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        r_state;
    op_e           r_op;
    logic [31:0]   r_a, r_b, r_hi, r_lo;
    logic          r_uns, r_start, r_err;
    logic [CW-1:0] r_cnt;

    op_e           w_req_op;
    logic          w_accept, w_done_ok, w_timeout, w_stall;
    logic [63:0]   w_acc;

    assign w_req_op  = op_e'(req_op);
    assign w_accept  = (r_state == S_IDLE) && req_valid && !flush && is_mul_op(w_req_op);
    assign w_done_ok = (r_state == S_WAIT) && mul_done && !flush;
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    hilo_acc u_acc (
        .i_op     (r_op),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_result (mul_result),
        .o_acc    (w_acc)
    );

    // Stall drops combinationally in the completion or flush cycle so EX can advance at that edge.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_accept;
            S_ISSUE: w_stall = !flush;
            S_WAIT:  w_stall = !(flush || mul_done);
            S_DRAIN: w_stall = req_valid;
            default: w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_uns   <= 1'b0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        if (w_req_op == OP_MTHI) begin
                            r_hi <= req_src_a;
                        end else if (w_req_op == OP_MTLO) begin
                            r_lo <= req_src_a;
                        end else if (is_mul_op(w_req_op)) begin
                            r_op    <= w_req_op;
                            r_a     <= req_src_a;
                            r_b     <= req_src_b;
                            r_uns   <= is_unsigned(w_req_op);
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                // The launch pulse already went out, so a flush here still has a product to drain.
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= mul_done ? S_IDLE : S_DRAIN;
                    end else if (mul_done) begin
                        if (r_op != OP_MUL) begin
                            {r_hi, r_lo} <= w_acc;
                        end
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (mul_done) begin
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_req    = w_stall;
    assign resp_valid   = w_done_ok && (r_op == OP_MUL);
    assign resp_data    = resp_valid ? mul_result[31:0] : '0;
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign mul_op1      = r_a;
    assign mul_op2      = r_b;
    assign mul_start    = r_start;
    assign mul_unsigned = r_uns;
    assign timeout_err  = r_err;
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed plus randomized bench for hilo_mul_ctrl; the bench also plays the 2-cycle multiplier.
module tb_hilo_mul_ctrl;
    localparam logic [3:0] OP_NONE  = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_MUL = 4'd3,
                           OP_MADD  = 4'd4, OP_MADDU = 4'd5, OP_MSUB = 4'd6, OP_MSUBU = 4'd7,
                           OP_MTHI  = 4'd8, OP_MTLO = 4'd9;

    logic        clock, reset, req_valid, flush, stall_req, resp_valid;
    logic        mul_start, mul_unsigned, mul_done, timeout_err;
    logic [3:0]  req_op;
    logic [31:0] req_src_a, req_src_b, resp_data, hi, lo, mul_op1, mul_op2;
    logic [63:0] mul_result;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] m_hilo;

    hilo_mul_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_src_a(req_src_a), .req_src_b(req_src_b), .flush(flush),
        .stall_req(stall_req), .resp_valid(resp_valid), .resp_data(resp_data),
        .hi(hi), .lo(lo), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_start(mul_start),
        .mul_unsigned(mul_unsigned), .mul_result(mul_result), .mul_done(mul_done),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic uns);
        longint sa, sb;
        if (uns) return {32'd0, a} * {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic op_uns(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_MADDU) || (op == OP_MSUBU);
    endfunction

    task automatic chk_hilo(input string tag);
        chk({tag, "_hi"}, 64'(hi), 64'(m_hilo[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(m_hilo[31:0]));
    endtask

    // Presents a multiply in IDLE (cycle N); returns at cycle N+1.
    task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_src_a = a; req_src_b = b;
        @(negedge clock);
        chk("accept_stall", 64'(stall_req), 64'd1);
        tick();
        req_valid = 1'b0; req_op = OP_NONE; req_src_a = $urandom; req_src_b = $urandom;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        req_valid = 1'b1; req_op = op; req_src_a = v; req_src_b = $urandom;
        @(negedge clock);
        chk("mt_nostall", 64'(stall_req), 64'd0);
        tick();
        req_valid = 1'b0; req_op = OP_NONE;
        if (op == OP_MTHI) m_hilo[63:32] = v; else m_hilo[31:0] = v;
        @(negedge clock);
        chk_hilo("mt");
        tick();
    endtask

    task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = prod(a, b, op_uns(op));
        accept(op, a, b);
        @(negedge clock);
        chk("start_n1", 64'(mul_start), 64'd1);
        chk("op1", 64'(mul_op1), 64'(a));
        chk("op2", 64'(mul_op2), 64'(b));
        chk("uns_n1", 64'(mul_unsigned), 64'(op_uns(op)));
        chk("stall_n1", 64'(stall_req), 64'd1);
        tick();
        @(negedge clock);
        chk("start_n2", 64'(mul_start), 64'd0);
        chk("stall_n2", 64'(stall_req), 64'd1);
        tick();
        mul_done = 1'b1;
        mul_result = prod(mul_op1, mul_op2, mul_unsigned);
        @(negedge clock);
        chk("stall_n3", 64'(stall_req), 64'd0);
        chk("uns_n3", 64'(mul_unsigned), 64'(op_uns(op)));
        chk("resp_valid", 64'(resp_valid), 64'(op == OP_MUL));
        if (op == OP_MUL) chk("resp_data", 64'(resp_data), 64'(p[31:0]));
        tick();
        mul_done = 1'b0; mul_result = {$urandom, $urandom};
        case (op)
            OP_MULT, OP_MULTU: m_hilo = p;
            OP_MADD, OP_MADDU: m_hilo = m_hilo + p;
            OP_MSUB, OP_MSUBU: m_hilo = m_hilo - p;
            default: ;
        endcase
        @(negedge clock);
        chk_hilo("commit");
        tick();
    endtask

    initial begin
        logic [3:0] ops [9];
        logic [3:0] rop;
        ops = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO};
        reset = 1'b0; req_valid = 1'b0; req_op = OP_NONE; req_src_a = '0; req_src_b = '0;
        flush = 1'b0; mul_done = 1'b0; mul_result = '0; m_hilo = '0;
        tick(); tick();
        @(negedge clock);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_start", 64'(mul_start), 64'd0);
        chk("rst_op1", 64'(mul_op1), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        run_mul(OP_MULT, 32'hFFFFFFFF, 32'd2);
        chk("mult_const", {32'(hi), 32'(lo)}, 64'hFFFFFFFF_FFFFFFFE);
        run_mul(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        chk("multu_const", {32'(hi), 32'(lo)}, 64'h00000001_FFFFFFFE);
        mt(OP_MTHI, 32'd0);
        mt(OP_MTLO, 32'd5);
        run_mul(OP_MADD, 32'd3, 32'd4);
        chk("madd_const", {32'(hi), 32'(lo)}, 64'h00000000_00000011);
        run_mul(OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("msubu_const", {32'(hi), 32'(lo)}, 64'h00000002_00000010);
        run_mul(OP_MUL, 32'd7, 32'hFFFFFFFA);
        chk("mul_const", {32'(hi), 32'(lo)}, 64'h00000002_00000010);

        // Flush in WAIT; a request during DRAIN is held off until IDLE.
        accept(OP_MULT, 32'h1234, 32'h5678);
        tick();
        flush = 1'b1;
        @(negedge clock);
        chk("flush_wait_stall", 64'(stall_req), 64'd0);
        tick();
        flush = 1'b0; req_valid = 1'b1; req_op = OP_MTHI; req_src_a = 32'd9;
        mul_done = 1'b1; mul_result = 64'h1234 * 64'h5678;
        @(negedge clock);
        chk("drain_stall", 64'(stall_req), 64'd1);
        chk("drain_resp", 64'(resp_valid), 64'd0);
        tick();
        mul_done = 1'b0;
        @(negedge clock);
        chk("idle_mthi_nostall", 64'(stall_req), 64'd0);
        tick();
        req_valid = 1'b0; req_op = OP_NONE;
        m_hilo[63:32] = 32'd9;
        @(negedge clock);
        chk_hilo("after_drain");
        chk("mthi9", 64'(hi), 64'd9);
        tick();

        // Flush coinciding with mul_done on a MUL: no response, straight back to IDLE.
        accept(OP_MUL, 32'd11, 32'd13);
        tick(); tick();
        mul_done = 1'b1; flush = 1'b1; mul_result = 64'd143;
        @(negedge clock);
        chk("flushdone_resp", 64'(resp_valid), 64'd0);
        chk("flushdone_stall", 64'(stall_req), 64'd0);
        tick();
        mul_done = 1'b0; flush = 1'b0;
        mt(OP_MTLO, 32'hCAFE0001);

        // Flush in ISSUE still launches.
        accept(OP_MADD, 32'd100, 32'd200);
        flush = 1'b1;
        @(negedge clock);
        chk("flush_issue_start", 64'(mul_start), 64'd1);
        chk("flush_issue_stall", 64'(stall_req), 64'd0);
        tick();
        flush = 1'b0;
        tick();
        mul_done = 1'b1; mul_result = 64'd20000;
        tick();
        mul_done = 1'b0;
        @(negedge clock);
        chk_hilo("flush_issue");
        tick();

        // Late mul_done in IDLE, unknown opcode, and flush-killed requests are all ignored.
        mul_done = 1'b1; mul_result = 64'hDEAD_BEEF_0000_0001;
        @(negedge clock);
        chk("late_done_resp", 64'(resp_valid), 64'd0);
        tick();
        mul_done = 1'b0;
        req_valid = 1'b1; req_op = 4'd12; req_src_a = 32'd77;
        @(negedge clock);
        chk("badop_stall", 64'(stall_req), 64'd0);
        tick();
        req_op = OP_NONE;
        @(negedge clock);
        chk("none_start", 64'(mul_start), 64'd0);
        tick();
        flush = 1'b1; req_op = OP_MTHI; req_src_a = 32'd55;
        @(negedge clock);
        chk("flush_idle_mthi", 64'(stall_req), 64'd0);
        tick();
        req_op = OP_MULT;
        @(negedge clock);
        chk("flush_idle_mul_stall", 64'(stall_req), 64'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
        @(negedge clock);
        chk("flush_idle_start", 64'(mul_start), 64'd0);
        chk_hilo("ignored");
        tick();

        for (int i = 0; i < 30; i++) begin
            rop = ops[$urandom_range(8, 0)];
            if (rop == OP_MTHI || rop == OP_MTLO) mt(rop, $urandom);
            else run_mul(rop, $urandom, $urandom);
        end

        // Reset dropped mid-WAIT clears everything without waiting for a clock.
        mt(OP_MTHI, 32'hA5A5A5A5);
        accept(OP_MULT, 32'd3, 32'd3);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_stall", 64'(stall_req), 64'd0);
        chk("midrst_op1", 64'(mul_op1), 64'd0);
        m_hilo = '0;
        tick();
        reset = 1'b1;
        tick();

        // Timeout: no mul_done ever arrives.
        mt(OP_MTLO, 32'h0000BEEF);
        accept(OP_MULT, 32'd9, 32'd9);
        tick();
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            chk("to_wait_stall", 64'(stall_req), 64'd1);
            chk("to_wait_err", 64'(timeout_err), 64'd0);
            tick();
        end
        @(negedge clock);
        chk("to_stall", 64'(stall_req), 64'd0);
        chk("to_err", 64'(timeout_err), 64'd1);
        chk_hilo("to_nocommit");
        tick();
        mt(OP_MTHI, 32'd1);
        chk("to_sticky", 64'(timeout_err), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
